// File: rtl/seq_stage_fetch.sv
// seq_stage_fetch
//   Instruction fetch stage. Owns the program counter, reads a synchronous
//   program memory and presents one 16-bit instruction per cycle (with its
//   address and a valid flag) to the combinational read/decode stage.
//   Absorbs downstream stall, jump-redirect and sticky halt requests.
//
// Parameters
//   ADDRESS_SIZE    : program-memory address width / PC width
//   NOP_INSTRUCTION : word driven on o_instruction when nothing valid is shown
//
// Ports
//   i_clk, i_rst_n  : clock (rising edge), asynchronous active-low reset
//   i_stall         : downstream cannot accept; hold all state
//   i_jump          : redirect fetch to i_jump_address, squash in-flight read
//   i_jump_address  : jump target
//   i_halt          : stop fetching; sticky until reset
//   o_pmem_address  : program-memory address (combinational from fetch PC)
//   o_pmem_en       : program-memory read enable
//   i_pmem_data     : program-memory read data, valid the cycle after a read
//   o_instruction   : registered instruction to the read stage
//   o_pc            : registered address of o_instruction
//   o_valid         : o_instruction is a real instruction
//   o_halted        : fetch is in the HALTED state
module seq_stage_fetch #(
  parameter int unsigned ADDRESS_SIZE    = 10,
  parameter logic [15:0] NOP_INSTRUCTION = 16'h0000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_stall,
  input  logic                    i_jump,
  input  logic [ADDRESS_SIZE-1:0] i_jump_address,
  input  logic                    i_halt,
  output logic [ADDRESS_SIZE-1:0] o_pmem_address,
  output logic                    o_pmem_en,
  input  logic [15:0]             i_pmem_data,
  output logic [15:0]             o_instruction,
  output logic [ADDRESS_SIZE-1:0] o_pc,
  output logic                    o_valid,
  output logic                    o_halted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t                  state,          state_next;
  logic [ADDRESS_SIZE-1:0] fetch_pc,       fetch_pc_next;
  logic                    inflight_valid, inflight_valid_next;
  logic [ADDRESS_SIZE-1:0] inflight_pc,    inflight_pc_next;
  logic [15:0]             instr_next;
  logic [ADDRESS_SIZE-1:0] pc_next;
  logic                    valid_next;

  assign o_pmem_address = fetch_pc;
  assign o_halted       = (state == HALTED);

  // A jump must read even while stalled so the redirect is not lost; the
  // squashed in-flight word is discarded by clearing inflight_valid. A plain
  // stall keeps the memory disabled so its output still holds the in-flight
  // word when the stall releases.
  assign o_pmem_en = (state == RUN) & ~i_halt & (i_jump | ~i_stall);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= RUN;
      fetch_pc       <= '0;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
      o_instruction  <= NOP_INSTRUCTION;
      o_pc           <= '0;
      o_valid        <= 1'b0;
    end else begin
      state          <= state_next;
      fetch_pc       <= fetch_pc_next;
      inflight_valid <= inflight_valid_next;
      inflight_pc    <= inflight_pc_next;
      o_instruction  <= instr_next;
      o_pc           <= pc_next;
      o_valid        <= valid_next;
    end
  end

  // Priority inside RUN: halt > jump > stall > advance. HALTED holds everything.
  always_comb begin
    state_next          = state;
    fetch_pc_next       = fetch_pc;
    inflight_valid_next = inflight_valid;
    inflight_pc_next    = inflight_pc;
    instr_next          = o_instruction;
    pc_next             = o_pc;
    valid_next          = o_valid;

    unique case (state)
      RUN: begin
        if (i_halt) begin
          state_next          = HALTED;
          inflight_valid_next = 1'b0;
          valid_next          = 1'b0;
          instr_next          = NOP_INSTRUCTION;
        end else if (i_jump) begin
          fetch_pc_next       = i_jump_address;
          inflight_valid_next = 1'b0;
          valid_next          = 1'b0;
          instr_next          = NOP_INSTRUCTION;
        end else if (!i_stall) begin
          inflight_valid_next = 1'b1;
          inflight_pc_next    = fetch_pc;
          fetch_pc_next       = fetch_pc + ADDRESS_SIZE'(1);
          valid_next          = inflight_valid;
          pc_next             = inflight_pc;
          instr_next          = inflight_valid ? i_pmem_data : NOP_INSTRUCTION;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_stage_fetch.sv
module tb_seq_stage_fetch;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        jump;
  logic [9:0]  jump_addr;
  logic        halt;
  logic [9:0]  pmem_address;
  logic        pmem_en;
  logic [15:0] pmem_data;
  logic [15:0] o_instruction;
  logic [9:0]  o_pc;
  logic        o_valid;
  logic        o_halted;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a fetch pointer, one in-flight token, and the
  // expected visible outputs. Instruction words are address + 16'h1000.
  int m_next;
  int m_infl_pc;
  bit m_infl_v;
  bit m_halted;
  bit e_valid;
  int e_pc;
  int e_instr;

  seq_stage_fetch #(
    .ADDRESS_SIZE   (10),
    .NOP_INSTRUCTION(NOP)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_stall       (stall),
    .i_jump        (jump),
    .i_jump_address(jump_addr),
    .i_halt        (halt),
    .o_pmem_address(pmem_address),
    .o_pmem_en     (pmem_en),
    .i_pmem_data   (pmem_data),
    .o_instruction (o_instruction),
    .o_pc          (o_pc),
    .o_valid       (o_valid),
    .o_halted      (o_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program memory: data appears the cycle after an enabled
  // read and holds otherwise.
  initial pmem_data = 16'h0000;
  always @(posedge clk) begin
    if (pmem_en) pmem_data <= 16'h1000 + {6'b0, pmem_address};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_next    = 0;
    m_infl_pc = 0;
    m_infl_v  = 0;
    m_halted  = 0;
    e_valid   = 0;
    e_pc      = 0;
    e_instr   = 0;
  endtask

  task automatic model_edge(input bit s, input bit j, input int ja, input bit h);
    if (m_halted) return;
    if (h) begin
      m_halted = 1;
      m_infl_v = 0;
      e_valid  = 0;
      e_instr  = 0;
    end else if (j) begin
      m_next   = ja;
      m_infl_v = 0;
      e_valid  = 0;
      e_instr  = 0;
    end else if (!s) begin
      e_valid   = m_infl_v;
      e_pc      = m_infl_pc;
      e_instr   = m_infl_v ? (32'h1000 + m_infl_pc) : 0;
      m_infl_v  = 1;
      m_infl_pc = m_next;
      m_next    = (m_next + 1) % 1024;
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance the
  // model at the rising edge, return 1 time unit after it.
  task automatic step(input bit s, input bit j, input logic [9:0] ja, input bit h);
    stall = s; jump = j; jump_addr = ja; halt = h;
    @(negedge clk);
    chk("valid",      {31'b0, o_valid},  {31'b0, e_valid});
    chk("pc",         {22'b0, o_pc},     e_pc);
    chk("instr",      {16'b0, o_instruction}, e_instr);
    chk("halted",     {31'b0, o_halted}, {31'b0, m_halted});
    chk("pmem_en",    {31'b0, pmem_en},  {31'b0, (!m_halted && !h && (j || !s))});
    chk("pmem_addr",  {22'b0, pmem_address}, m_next);
    @(posedge clk);
    model_edge(s, j, int'(ja), h);
    #1;
  endtask

  task automatic run_until_pc(input string tag, input logic [9:0] target, input int bound);
    int n = 0;
    while (!(o_valid && o_pc == target) && n < bound) begin
      step(0, 0, '0, 0);
      n++;
    end
    chk(tag, {22'b0, o_pc}, {22'b0, target});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"},  {31'b0, o_valid},  0);
    chk({tag, "_pc"},     {22'b0, o_pc},     0);
    chk({tag, "_instr"},  {16'b0, o_instruction}, {16'b0, NOP});
    chk({tag, "_halted"}, {31'b0, o_halted}, 0);
    chk({tag, "_addr"},   {22'b0, pmem_address}, 0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; jump = 1'b0; jump_addr = '0; halt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Cycles 0,1: empty pipe; cycle 2: first instruction at address 0.
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    chk("first_valid", {31'b0, o_valid}, 1);
    chk("first_pc",    {22'b0, o_pc}, 0);
    chk("first_instr", {16'b0, o_instruction}, 32'h1000);
    repeat (4) step(0, 0, '0, 0);         // cycles 2..5
    step(0, 1, 10'h155, 0);               // jump in cycle 6
    chk("jump_bubble1", {31'b0, o_valid}, 0);
    step(0, 0, '0, 0);
    chk("jump_bubble2", {31'b0, o_valid}, 0);
    step(0, 0, '0, 0);
    chk("jump_target_pc",    {22'b0, o_pc}, 32'h155);
    chk("jump_target_instr", {16'b0, o_instruction}, 32'h1155);
    chk("jump_target_valid", {31'b0, o_valid}, 1);
    step(0, 0, '0, 0);
    chk("jump_next_pc", {22'b0, o_pc}, 32'h156);

    // Stall for 3 cycles while o_pc = 5.
    step(0, 1, 10'h003, 0);
    run_until_pc("wait_pc5", 10'h005, 10);
    for (int unsigned i = 0; i < 3; i++) begin
      step(1, 0, '0, 0);
      chk("stall_hold_pc",    {22'b0, o_pc}, 5);
      chk("stall_hold_instr", {16'b0, o_instruction}, 32'h1005);
      chk("stall_hold_valid", {31'b0, o_valid}, 1);
    end
    step(0, 0, '0, 0);
    chk("stall_release_pc", {22'b0, o_pc}, 6);

    // Jump asserted during a stall is taken.
    step(1, 0, '0, 0);
    step(1, 1, 10'h020, 0);
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    run_until_pc("stall_jump_pc", 10'h020, 6);

    // PC wrap-around.
    step(0, 1, 10'h3FE, 0);
    run_until_pc("wrap_3fe", 10'h3FE, 6);
    step(0, 0, '0, 0);
    chk("wrap_3ff", {22'b0, o_pc}, 32'h3FF);
    step(0, 0, '0, 0);
    chk("wrap_000", {22'b0, o_pc}, 0);
    step(0, 0, '0, 0);
    chk("wrap_001", {22'b0, o_pc}, 1);

    // Randomized stall/jump traffic against the model.
    for (int unsigned i = 0; i < 300; i++) begin
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6,
           10'($urandom_range(0, 1023)), 0);
    end

    // Halt together with jump: halt wins and is sticky.
    step(0, 1, 10'h099, 1);
    chk("halt_halted", {31'b0, o_halted}, 1);
    chk("halt_valid",  {31'b0, o_valid}, 0);
    chk("halt_en",     {31'b0, pmem_en}, 0);
    for (int unsigned i = 0; i < 20; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1),
           10'($urandom_range(0, 1023)), $urandom_range(0, 1));
    end
    chk("halt_sticky", {31'b0, o_halted}, 1);

    // Reset out of HALTED, restart, then asynchronous reset at o_pc = 7.
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("halt_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_until_pc("wait_pc7", 10'h007, 12);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    chk("restart_valid", {31'b0, o_valid}, 1);
    chk("restart_pc",    {22'b0, o_pc}, 0);
    for (int unsigned i = 0; i < 100; i++) begin
      step($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 5,
           10'($urandom_range(0, 1023)), $urandom_range(0, 99) < 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
